// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the unified-memory arbiter.
// Optional perf counters in mem_arbiter are enabled with MEM_ARB_PERF_EN.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_IF = 2'd1,
    RD_D  = 2'd2
  } arbState_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  localparam int CNT_W    = 3;
  localparam int STARVE_W = 3;

endpackage

// File: rtl/mem_arb_prio.sv
// Grant selection for IF vs D: combinational, only in IDLE, data first unless IF starved.
// No internal state; requesters hold their request until granted.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 3
) (
  input  logic                if_req,
  input  logic                d_req,
  input  logic [STARVE_W-1:0] starve,
  input  arbState_t           state,
  output logic                if_gnt,
  output logic                d_gnt
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (state == IDLE) begin
      if (d_req && !(if_req && starve == STARVE_LIM)) begin
        d_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for IF and D ports: grant issued combinationally, reads return LAT cycles later.
// Requests wait (stall asserted) while busy; MEM_ARB_PERF_EN adds conflict/stall counters.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LAT        = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [15:0]       conflict_cnt,
  output logic [15:0]       stall_cnt
`endif
);

  localparam logic [CNT_W-1:0]    LAT_C      = CNT_W'(LAT);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  arbState_t           state;
  logic [CNT_W-1:0]    cnt;
  logic [STARVE_W-1:0] starve;
  logic                ifGntRaw;
  logic                dGntRaw;
  logic                rdDone;
  logic                rdOwner;
  logic                stallRaw;

  mem_arb_prio #(
    .STARVE_MAX(STARVE_MAX)
  ) uPrio (
    .if_req (if_req),
    .d_req  (d_req),
    .starve (starve),
    .state  (state),
    .if_gnt (ifGntRaw),
    .d_gnt  (dGntRaw)
  );

  // Everything visible is forced low while reset is asserted, even the combinational grants.
  assign if_gnt = ifGntRaw & reset;
  assign d_gnt  = dGntRaw & reset;

  assign mem_en    = if_gnt | d_gnt;
  assign mem_we    = d_gnt & d_we;
  assign mem_addr  = d_gnt ? d_addr  : (if_gnt ? if_addr : '0);
  assign mem_wdata = d_gnt ? d_wdata : '0;

  assign rdDone    = (state != IDLE) && (cnt == LAT_C);
  assign rdOwner   = (state == RD_D) ? OWN_D : OWN_IF;
  assign if_rvalid = reset & rdDone & (rdOwner == OWN_IF);
  assign d_rvalid  = reset & rdDone & (rdOwner == OWN_D);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid  ? mem_rdata : '0;

  assign stallRaw = (state != IDLE) | (if_req & ~ifGntRaw) | (d_req & ~dGntRaw);
  assign stall    = stallRaw & reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      starve <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ifGntRaw) begin
            state <= RD_IF;
            cnt   <= CNT_W'(1);
          end else if (dGntRaw && !d_we) begin
            state <= RD_D;
            cnt   <= CNT_W'(1);
          end
          // Stores stay in IDLE so they can issue every cycle.
          if (ifGntRaw || !if_req) begin
            starve <= '0;
          end else if (dGntRaw && starve != STARVE_LIM) begin
            starve <= starve + 1'b1;
          end
        end
        RD_IF, RD_D: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAT_C) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflict_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      if (state == IDLE && if_req && d_req && conflict_cnt != 16'hFFFF) begin
        conflict_cnt <= conflict_cnt + 16'd1;
      end
      if (stallRaw && stall_cnt != 16'hFFFF) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (LAT=2, STARVE_MAX=3); perf checks only when MEM_ARB_PERF_EN is defined.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stall;
`ifdef MEM_ARB_PERF_EN
  logic [15:0] conflict_cnt;
  logic [15:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .LAT(2), .STARVE_MAX(3)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall(stall)
`ifdef MEM_ARB_PERF_EN
    , .conflict_cnt(conflict_cnt), .stall_cnt(stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic probe();
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    if_req = 1'b0;
    d_req  = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      probe();
      if (stall === 1'b0) done = 1'b1;
      step();
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s.drain stall still high after 10 cycles, want 0", name);
    end
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    if_req = 1'b1;
    d_req  = 1'b1;
    d_we   = 1'b0;
    probe();
    total++; if (if_gnt !== 1'b0) begin bad++; $display("FAIL reset.if_gnt got=%b want=0", if_gnt); end
    total++; if (d_gnt !== 1'b0) begin bad++; $display("FAIL reset.d_gnt got=%b want=0", d_gnt); end
    total++; if (mem_en !== 1'b0 || mem_addr !== 32'h0) begin bad++; $display("FAIL reset.mem got en=%b addr=%h want 0/0", mem_en, mem_addr); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset.stall got=%b want=0", stall); end
    if_req = 1'b0;
    d_req  = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic test_if_read();
    if_req    = 1'b1;
    if_addr   = 32'h10;
    mem_rdata = 32'h8C010004;
    probe();
    total++; if (if_gnt !== 1'b1 || d_gnt !== 1'b0) begin bad++; $display("FAIL if_read.gnt0 got if=%b d=%b want 1/0", if_gnt, d_gnt); end
    total++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h10) begin bad++; $display("FAIL if_read.mem0 got en=%b we=%b addr=%h want 1/0/10", mem_en, mem_we, mem_addr); end
    step();
    probe();
    total++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h0 || if_gnt !== 1'b0 || stall !== 1'b1) begin bad++; $display("FAIL if_read.c1 got rv=%b rd=%h gnt=%b stall=%b want 0/0/0/1", if_rvalid, if_rdata, if_gnt, stall); end
    step();
    probe();
    total++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h8C010004) begin bad++; $display("FAIL if_read.c2 got rv=%b rd=%h want 1/8c010004", if_rvalid, if_rdata); end
    total++; if (d_rvalid !== 1'b0 || d_rdata !== 32'h0) begin bad++; $display("FAIL if_read.d_side got rv=%b rd=%h want 0/0", d_rvalid, d_rdata); end
    step();
    probe();
    total++; if (if_gnt !== 1'b1 || if_rvalid !== 1'b0) begin bad++; $display("FAIL if_read.c3 got gnt=%b rv=%b want 1/0", if_gnt, if_rvalid); end
    step();
    drain("if_read");
  endtask

  task automatic test_both_load();
    if_req    = 1'b1;
    if_addr   = 32'h14;
    d_req     = 1'b1;
    d_we      = 1'b0;
    d_addr    = 32'h40;
    mem_rdata = 32'h11112222;
    probe();
    total++; if (d_gnt !== 1'b1 || if_gnt !== 1'b0 || mem_addr !== 32'h40) begin bad++; $display("FAIL both.c0 got d=%b if=%b addr=%h want 1/0/40", d_gnt, if_gnt, mem_addr); end
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL both.stall0 got=%b want=1", stall); end
    step();
    d_req = 1'b0;
    probe();
    total++; if (stall !== 1'b1 || d_rvalid !== 1'b0 || if_gnt !== 1'b0) begin bad++; $display("FAIL both.c1 got stall=%b rv=%b ifg=%b want 1/0/0", stall, d_rvalid, if_gnt); end
    step();
    probe();
    total++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h11112222 || if_rvalid !== 1'b0) begin bad++; $display("FAIL both.c2 got rv=%b rd=%h ifrv=%b want 1/11112222/0", d_rvalid, d_rdata, if_rvalid); end
    total++; if (stall !== 1'b1 || if_gnt !== 1'b0) begin bad++; $display("FAIL both.stall2 got stall=%b ifg=%b want 1/0", stall, if_gnt); end
    step();
    probe();
    total++; if (if_gnt !== 1'b1 || mem_addr !== 32'h14 || mem_we !== 1'b0) begin bad++; $display("FAIL both.c3 got ifg=%b addr=%h we=%b want 1/14/0", if_gnt, mem_addr, mem_we); end
    step();
    drain("both");
  endtask

  task automatic test_starve();
    if_req  = 1'b1;
    if_addr = 32'h18;
    d_req   = 1'b1;
    d_we    = 1'b1;
    for (int c = 0; c < 4; c++) begin
      d_addr  = 32'h100 + 32'(c);
      d_wdata = 32'hA0 + 32'(c);
      probe();
      total++;
      if (d_gnt !== (c < 3) || if_gnt !== (c == 3) || mem_we !== (c < 3)) begin
        bad++;
        $display("FAIL starve.c%0d got d=%b if=%b we=%b want %b/%b/%b", c, d_gnt, if_gnt, mem_we, c < 3, c == 3, c < 3);
      end
      step();
    end
    drain("starve");
  endtask

  task automatic test_store();
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h20;
    d_wdata = 32'hDEADBEEF;
    probe();
    total++; if (d_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1) begin bad++; $display("FAIL store.c0 got g=%b en=%b we=%b want 1/1/1", d_gnt, mem_en, mem_we); end
    total++; if (mem_addr !== 32'h20 || mem_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL store.data got addr=%h wd=%h want 20/deadbeef", mem_addr, mem_wdata); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL store.stall0 got=%b want=0", stall); end
    step();
    d_req = 1'b0;
    probe();
    total++; if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin bad++; $display("FAIL store.c1 got en=%b we=%b addr=%h wd=%h want all 0", mem_en, mem_we, mem_addr, mem_wdata); end
    total++; if (d_rvalid !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL store.c1b got rv=%b stall=%b want 0/0", d_rvalid, stall); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [4];
    addrs[0] = 32'h200; addrs[1] = 32'h204; addrs[2] = 32'h300; addrs[3] = 32'hFFFFFFFC;
    d_req = 1'b1;
    d_we  = 1'b1;
    for (int c = 0; c < 4; c++) begin
      d_addr  = addrs[c];
      d_wdata = ~addrs[c];
      probe();
      total++;
      if (d_gnt !== 1'b1 || mem_addr !== addrs[c] || mem_wdata !== ~addrs[c] || stall !== 1'b0) begin
        bad++;
        $display("FAIL b2b.c%0d got g=%b addr=%h wd=%h stall=%b want 1/%h/%h/0", c, d_gnt, mem_addr, mem_wdata, stall, addrs[c], ~addrs[c]);
      end
      step();
    end
    drain("b2b");
  endtask

  task automatic test_reset_inflight();
    if_req    = 1'b1;
    if_addr   = 32'h30;
    mem_rdata = 32'h55AA55AA;
    probe();
    total++; if (if_gnt !== 1'b1) begin bad++; $display("FAIL rst_fl.gnt got=%b want=1", if_gnt); end
    step();
    reset = 1'b0;
    #1;
    total++; if (if_gnt !== 1'b0 || mem_en !== 1'b0 || stall !== 1'b0 || if_rvalid !== 1'b0) begin bad++; $display("FAIL rst_fl.low got g=%b en=%b stall=%b rv=%b want 0/0/0/0", if_gnt, mem_en, stall, if_rvalid); end
    step();
    reset = 1'b1;
    probe();
    total++; if (if_gnt !== 1'b1 || if_rvalid !== 1'b0 || mem_addr !== 32'h30) begin bad++; $display("FAIL rst_fl.regrant got g=%b rv=%b addr=%h want 1/0/30", if_gnt, if_rvalid, mem_addr); end
    step();
    if_req = 1'b0;
    probe();
    total++; if (if_rvalid !== 1'b0) begin bad++; $display("FAIL rst_fl.c1 got rv=%b want=0", if_rvalid); end
    step();
    probe();
    total++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h55AA55AA) begin bad++; $display("FAIL rst_fl.c2 got rv=%b rd=%h want 1/55aa55aa", if_rvalid, if_rdata); end
    step();
    drain("rst_fl");
  endtask

`ifdef MEM_ARB_PERF_EN
  task automatic test_perf();
    reset = 1'b0;
    step();
    reset = 1'b1;
    total++; if (conflict_cnt !== 16'h0 || stall_cnt !== 16'h0) begin bad++; $display("FAIL perf.reset got c=%h s=%h want 0/0", conflict_cnt, stall_cnt); end
    // Stores from D with IF held: D,D,D,IF(+2 read cycles),D -> 5 idle conflicts, 7 stalled cycles.
    if_req = 1'b1;
    d_req  = 1'b1;
    d_we   = 1'b1;
    for (int c = 0; c < 7; c++) step();
    if_req = 1'b0;
    d_req  = 1'b0;
    probe();
    total++; if (conflict_cnt !== 16'd5) begin bad++; $display("FAIL perf.conflict got=%0d want=5", conflict_cnt); end
    total++; if (stall_cnt !== 16'd7) begin bad++; $display("FAIL perf.stall got=%0d want=7", stall_cnt); end
    step();
    if_req = 1'b1;
    d_req  = 1'b1;
    for (int c = 0; c < 65600; c++) step();
    probe();
    total++; if (stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL perf.sat got=%h want=ffff", stall_cnt); end
    step();
    probe();
    total++; if (stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL perf.hold got=%h want=ffff", stall_cnt); end
    step();
    drain("perf");
  endtask
`endif

  initial begin
    reset     = 1'b0;
    if_req    = 1'b0;
    if_addr   = 32'h0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = 32'h0;
    d_wdata   = 32'h0;
    mem_rdata = 32'h0;
    test_reset();
    test_if_read();
    test_both_load();
    test_starve();
    test_store();
    test_back_to_back();
    test_reset_inflight();
`ifdef MEM_ARB_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch port (IF) and the load/store port (D) of the MIPS core.
- Issues one access at a time, with data priority and bounded IF starvation.
- Sequences the fixed read latency of the memory and returns read data to whichever port owns the access.
- Drives `stall` to freeze the program counter and register-file writes while an access is pending or a request is waiting.

Parameters:
- ADDR_W, 32, address width of both ports and the memory.
- DATA_W, 32, data width.
- LAT, 2, memory read latency in cycles; legal range 1..4.
- STARVE_MAX, 3, number of consecutive D grants with IF waiting before IF is forced to win.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  IF read request; held until granted.
- if_addr  in  ADDR_W  IF address.
- if_gnt  out  1  IF request accepted this cycle.
- if_rvalid  out  1  if_rdata valid this cycle.
- if_rdata  out  DATA_W  fetch data.
- d_req  in  1  D request; held until granted.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  D address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  D request accepted this cycle.
- d_rvalid  out  1  d_rdata valid this cycle (loads only).
- d_rdata  out  DATA_W  load data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid LAT cycles after the mem_en cycle.
- stall  out  1  core must hold PC and suppress register writes.

Behaviour:
- States:
  - IDLE.
  - RD_IF: IF read in flight.
  - RD_D: D read in flight.
- Latency counter:
  - `cnt` is 3 bits and counts 1..LAT.
  - Loaded with 1 on every read grant.
  - Increments each cycle while in RD_IF or RD_D.
- Grant logic (IDLE only, combinational):
  - With only one request pending, that request wins.
  - With both pending, D wins unless `starve == STARVE_MAX`, in which case IF wins.
  - No grants are issued outside IDLE.
- Memory drive in the grant cycle:
  - mem_en = 1.
  - mem_addr and mem_wdata are muxed from the winning port.
  - mem_we = d_we when D wins, else 0.
  - With no grant, mem_en = mem_we = 0 and mem_addr/mem_wdata are 0.
- After a grant:
  - A store returns to IDLE next cycle; there is no rvalid. Back-to-back stores sustain one per cycle.
  - A load or fetch moves to RD_D or RD_IF.
- Read completion:
  - In RD_x with `cnt == LAT`, x_rvalid = 1 and x_rdata = mem_rdata; next state is IDLE.
  - Read throughput is one per LAT+1 cycles.
  - x_rdata is 0 whenever x_rvalid = 0.
- Starvation counter `starve` (2..3 bits, saturating at STARVE_MAX):
  - Increments on a D grant while if_req = 1.
  - Cleared on any IF grant, or on an IDLE cycle with if_req = 0.
- stall = (state != IDLE) | (if_req & ~if_gnt) | (d_req & ~d_gnt).
- A request withdrawn before its grant is illegal and is not checked.
- Reset (low, asynchronous):
  - state = IDLE, cnt = 0, starve = 0.
  - All outputs are 0 while reset is low, including grants regardless of requests.
  - An in-flight read is discarded and no rvalid is produced after release.
- The first grant can occur in the first clk edge cycle after reset deasserts.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- With the macro defined:
  - Adds output ports conflict_cnt [15:0] and stall_cnt [15:0], both saturating at 16'hFFFF and reset to 0.
  - conflict_cnt increments on each IDLE cycle with if_req & d_req.
  - stall_cnt increments on each cycle with stall = 1.
- Without the macro: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package mem_arb_pkg holds:
  - the state typedef (IDLE, RD_IF, RD_D);
  - owner constants OWN_IF = 0, OWN_D = 1;
  - the counter width localparams.
- One sub-module, mem_arb_prio (combinational):
  - inputs: if_req, d_req, starve, state;
  - outputs: if_gnt, d_gnt.
- The FSM, counters and datapath muxes stay in mem_arbiter.

Test Plan:
- IF only, if_addr = 0x10, LAT = 2, mem_rdata = 0x8C010004 → if_gnt in cycle 0; if_rvalid = 1 with if_rdata = 0x8C010004 in cycle 2; next if_gnt in cycle 3.
- Simultaneous if_req and d_req load, d_addr = 0x40 → d_gnt first; IF granted in the IDLE cycle after d_rvalid; stall = 1 throughout.
- Continuous d_req stores with if_req held, STARVE_MAX = 3 → 3 d_gnt pulses on consecutive cycles, then if_gnt on the 4th; mem_we = 0 on that cycle.
- Store d_addr = 0x20, d_wdata = 0xDEADBEEF → single-cycle mem_en = mem_we = 1 with that address and data; no d_rvalid; stall = 0 the next cycle if no further requests.
- reset driven low one cycle after an IF read grant → all outputs 0 immediately (asynchronously); after release, no if_rvalid appears and the held if_req is re-granted on the first edge.
- MEM_ARB_PERF_EN, 5 IDLE cycles with both requesters active → conflict_cnt = 5; counters at 0xFFFF stay at 0xFFFF.
